decode_seq: RTL and testbench
=============================

# decode_seq

Parametrised, registered WIDTH-to-2^WIDTH one-hot decoder with a valid/ready input handshake and a second "scan" mode that walks the one-hot output through every line once. It replaces the fixed combinational 2-to-4 decoder wherever decoded selects must be registered, paced or swept, for example register-file write enables, display digit strobes and peripheral chip-selects.

## Interface
Parameters:
- WIDTH, 2, number of select bits; output width OUTS = 2^WIDTH (localparam); WIDTH >= 1
- HOLD, 1, cycles each scan step is held; HOLD >= 1

Ports:
- CLK  input  1  clock, rising edge
- Reset_L  input  1  asynchronous active-low reset
- en  input  1  global enable; 0 freezes the block
- mode  input  1  0 = direct decode, 1 = scan; sampled only on acceptance
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in  input  WIDTH  select value; in scan mode, the start line
- out  output  OUTS  registered one-hot (or all-inactive) select
- out_valid  output  1  out currently holds a decoded line
- index  output  WIDTH  binary index of the active line
- wrap  output  1  one-cycle pulse when scan steps from OUTS-1 to 0

## Operation
- States: IDLE, DIRECT, SCAN.
- Acceptance happens when in_valid && in_ready at a rising edge. in_ready = en && (state != SCAN).
- IDLE or DIRECT, accepted with mode=0: go to DIRECT; out = 1<<in, index = in, out_valid = 1. Output holds until the next acceptance.
- IDLE or DIRECT, accepted with mode=1: go to SCAN; out = 1<<in, index = in, out_valid = 1, hold counter = 0.
- SCAN: the hold counter increments on each edge with en=1. When it reaches HOLD-1, it clears and index advances by 1 modulo OUTS, and out follows.
- Stepping OUTS-1 to 0 asserts wrap for exactly that one cycle.
- After OUTS steps, when index would re-reach the start line: go to IDLE with out inactive, out_valid = 0, index unchanged.
- in_valid during SCAN is ignored and not queued.
- en = 0: no acceptance, hold counter frozen, all outputs held, wrap forced to 0.
- Reset (asynchronous, any state including mid-scan):
  - state = IDLE
  - out = inactive
  - out_valid = 0
  - index = 0
  - wrap = 0
  - hold counter = 0
- The index arithmetic is WIDTH bits wide and wraps naturally. No other width growth occurs.

## Timing
- Direct latency is 1 cycle: accept at edge t, out valid after edge t.
- Back-to-back direct requests are accepted every cycle. in_ready stays 1 in DIRECT while en=1.
- Scan started at edge t with start line s:
  - line s active from edge t through edge t+HOLD
  - line s+k active after edge t+k*HOLD, for k < OUTS
  - return to IDLE after edge t+OUTS*HOLD; in_ready = 1 from that cycle
- Each cycle with en=0 during SCAN extends the schedule by one cycle.
- in_ready is combinational from state and en. All other outputs are registered.

## Configuration
- DECODE_ACTIVE_LOW_EN defined:
  - out is active-low: selected bit 0, others 1
  - inactive/reset value is all ones
  - out_valid, wrap and in_ready keep active-high polarity
- Undefined (default):
  - out is active-high one-hot
  - inactive/reset value is all zeros

## Test plan
- Reset: with Reset_L=0, check out=0, out_valid=0, index=0, wrap=0, in_ready=0 (en=0) and in_ready=1 (en=1). Release reset and check nothing changes until the first acceptance.
- Direct, WIDTH=2: in = 0, 1, 2, 3 on consecutive cycles with mode=0 -> out = 1, 2, 4, 8 one cycle later each, index = in. With WIDTH=3, in=5 -> out = 8'h20.
- Scan, WIDTH=2, HOLD=1, start 2:
  - out = 4, 8, 1, 2 on successive cycles
  - wrap=1 only in the cycle with out=1
  - then out=0, out_valid=0, in_ready=1
  - in_valid with in=0 during the scan changes nothing
- Scan, HOLD=3, en dropped for 2 cycles on the second step -> each line is held 3 cycles, except the second line, which is held 5. Total scan length is 14 cycles.
- Reset_L pulsed low asynchronously between edges mid-scan -> outputs go to reset values immediately. The next accepted direct request (in=1) -> out=2.
- Build with DECODE_ACTIVE_LOW_EN, WIDTH=2:
  - reset out = 4'hF
  - direct in=2 -> out = 4'hB
  - scan from 0 -> E, D, B, 7, then F

Source files
------------

// File: rtl/decode_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_seq_if
//  Description : Handshake and select bus for decode_seq.
//                master : drives en, mode, in_valid, in; observes the rest
//                slave  : the decoder side
//  Ports       : en, mode, in_valid, in_ready, in[WIDTH-1:0],
//                out[2^WIDTH-1:0], out_valid, index[WIDTH-1:0], wrap
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_seq_if #(
    parameter int WIDTH = 2
);
    localparam int OUTS = 2 ** WIDTH;

    logic             en;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic [OUTS-1:0]  out;
    logic             out_valid;
    logic [WIDTH-1:0] index;
    logic             wrap;

    modport master (
        output en, mode, in_valid, in,
        input  in_ready, out, out_valid, index, wrap
    );

    modport slave (
        input  en, mode, in_valid, in,
        output in_ready, out, out_valid, index, wrap
    );
endinterface
`default_nettype wire

// File: rtl/decode_seq.sv
`default_nettype none
// ============================================================================
//  Module      : decode_seq
//  Description : Registered WIDTH-to-2^WIDTH one-hot decoder with valid/ready
//                input handshake. Direct mode decodes one request and holds
//                it; scan mode walks the active line through every output
//                once, holding each line HOLD enabled cycles.
//  Ports       : CLK      - clock, rising edge
//                Reset_L  - asynchronous active-low reset
//                bus      - decode_seq_if.slave (en, mode, in_valid,
//                           in_ready, in, out, out_valid, index, wrap)
//  Config      : `define DECODE_ACTIVE_LOW_EN makes out active-low
//                (selected bit 0, inactive value all ones).
//  Revision    : 1.0  initial release
// ============================================================================
module decode_seq #(
    parameter int WIDTH = 2,
    parameter int HOLD  = 1
) (
    input  wire logic     CLK,
    input  wire logic     Reset_L,
    decode_seq_if.slave   bus
);
    localparam int OUTS = 2 ** WIDTH;
    localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD - 1);

`ifdef DECODE_ACTIVE_LOW_EN
    localparam logic [OUTS-1:0] C_INACTIVE = {OUTS{1'b1}};
`else
    localparam logic [OUTS-1:0] C_INACTIVE = {OUTS{1'b0}};
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [OUTS-1:0]  r_out;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_index;
    logic [WIDTH-1:0] r_start;
    logic             r_wrap;
    logic [HW-1:0]    r_hold;

    logic             w_accept;
    logic [WIDTH-1:0] w_next;

    // Polarity is folded in here so the registered value is already final.
    function automatic logic [OUTS-1:0] line_sel(input logic [WIDTH-1:0] idx);
        logic [OUTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v ^ C_INACTIVE;
    endfunction

    assign bus.in_ready = bus.en && (r_state != S_SCAN);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_next       = r_index + WIDTH'(1);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state     <= S_IDLE;
            r_out       <= C_INACTIVE;
            r_out_valid <= 1'b0;
            r_index     <= '0;
            r_start     <= '0;
            r_wrap      <= 1'b0;
            r_hold      <= '0;
        end else begin
            // wrap is a single-cycle pulse; any edge that does not step
            // across OUTS-1 -> 0 (including frozen edges) clears it.
            r_wrap <= 1'b0;
            if (bus.en) begin
                case (r_state)
                    S_IDLE, S_DIRECT: begin
                        if (w_accept) begin
                            r_out       <= line_sel(bus.in);
                            r_index     <= bus.in;
                            r_start     <= bus.in;
                            r_out_valid <= 1'b1;
                            r_hold      <= '0;
                            r_state     <= bus.mode ? S_SCAN : S_DIRECT;
                        end
                    end
                    S_SCAN: begin
                        if (r_hold == C_HOLD_LAST) begin
                            r_hold <= '0;
                            // Coming back round to the start line ends the
                            // sweep; index keeps the last line shown.
                            if (w_next == r_start) begin
                                r_state     <= S_IDLE;
                                r_out       <= C_INACTIVE;
                                r_out_valid <= 1'b0;
                            end else begin
                                r_index <= w_next;
                                r_out   <= line_sel(w_next);
                                r_wrap  <= (w_next == '0);
                            end
                        end else begin
                            r_hold <= r_hold + HW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.index     = r_index;
    assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decode_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_seq
//  Description : Self-checking bench for decode_seq. Three instances:
//                A: WIDTH=2 HOLD=1, B: WIDTH=2 HOLD=3, C: WIDTH=3 HOLD=1.
//                A schedule-level model predicts every output each cycle;
//                directed literal checks pin key values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_seq;
    logic CLK = 1'b0;
    logic Reset_L = 1'b0;
    always #5 CLK = ~CLK;

    decode_seq_if #(.WIDTH(2)) ia ();
    decode_seq_if #(.WIDTH(2)) ib ();
    decode_seq_if #(.WIDTH(3)) ic ();

    decode_seq #(.WIDTH(2), .HOLD(1)) dut_a (.CLK(CLK), .Reset_L(Reset_L), .bus(ia));
    decode_seq #(.WIDTH(2), .HOLD(3)) dut_b (.CLK(CLK), .Reset_L(Reset_L), .bus(ib));
    decode_seq #(.WIDTH(3), .HOLD(1)) dut_c (.CLK(CLK), .Reset_L(Reset_L), .bus(ic));

    int nchk = 0;
    int nerr = 0;

    // ---------------- model ----------------
    // st: 0 idle, 1 direct, 2 scan. line < 0 means no line shown.
    // elapsed counts enabled edges since the scan was accepted.
    typedef struct {
        int st;
        int line;
        bit vld;
        int idx;
        bit wrp;
        int start;
        int elapsed;
    } mdl_t;

    mdl_t m[3];

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = 0; r.line = -1; r.vld = 0; r.idx = 0;
        r.wrp = 0; r.start = 0; r.elapsed = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int outs, int hold,
                                   bit en, bit mode, bit valid, int in);
        mdl_t n;
        n = s;
        n.wrp = 0;
        if (!en) return n;
        if (s.st != 2) begin
            if (valid) begin
                n.idx = in; n.line = in; n.vld = 1;
                if (mode) begin
                    n.st = 2; n.start = in; n.elapsed = 0;
                end else begin
                    n.st = 1;
                end
            end
        end else begin
            n.elapsed = s.elapsed + 1;
            if (n.elapsed == outs * hold) begin
                n.st = 0; n.vld = 0; n.line = -1;
            end else if (n.elapsed % hold == 0) begin
                n.idx  = (s.start + n.elapsed / hold) % outs;
                n.line = n.idx;
                n.wrp  = (n.idx == 0);
            end
        end
        return n;
    endfunction

    always @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            m[0] <= mreset();
            m[1] <= mreset();
            m[2] <= mreset();
        end else begin
            m[0] <= mstep(m[0], 4, 1, ia.en, ia.mode, ia.in_valid, int'(ia.in));
            m[1] <= mstep(m[1], 4, 3, ib.en, ib.mode, ib.in_valid, int'(ib.in));
            m[2] <= mstep(m[2], 8, 1, ic.en, ic.mode, ic.in_valid, int'(ic.in));
        end
    end

    // Convert an active-high pattern to the build's output polarity.
    function automatic logic [63:0] pol(logic [63:0] v, int outs);
        logic [63:0] mask;
        mask = (64'd1 << outs) - 64'd1;
`ifdef DECODE_ACTIVE_LOW_EN
        return (~v) & mask;
`else
        return v & mask;
`endif
    endfunction

    function automatic logic [63:0] expo(int outs, int line);
        logic [63:0] v;
        v = (line < 0) ? 64'd0 : (64'd1 << line);
        return pol(v, outs);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp(string nm, int id, int outs, logic [63:0] o, logic v,
                       logic [63:0] idx, logic w, logic rdy, logic en);
        chk({nm, ".out"},       o,          expo(outs, m[id].line));
        chk({nm, ".out_valid"}, 64'(v),     64'(m[id].vld));
        chk({nm, ".index"},     idx,        64'(m[id].idx));
        chk({nm, ".wrap"},      64'(w),     64'(m[id].wrp));
        chk({nm, ".in_ready"},  64'(rdy),   64'(en && (m[id].st != 2)));
    endtask

    // Single compare process: every falling edge, all three instances.
    always @(negedge CLK) begin
        cmp("A", 0, 4, 64'(ia.out), ia.out_valid, 64'(ia.index), ia.wrap, ia.in_ready, ia.en);
        cmp("B", 1, 4, 64'(ib.out), ib.out_valid, 64'(ib.index), ib.wrap, ib.in_ready, ib.en);
        cmp("C", 2, 8, 64'(ic.out), ic.out_valid, 64'(ic.index), ic.wrap, ic.in_ready, ic.en);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int n;
        ia.en = 0; ia.mode = 0; ia.in_valid = 0; ia.in = '0;
        ib.en = 0; ib.mode = 0; ib.in_valid = 0; ib.in = '0;
        ic.en = 0; ic.mode = 0; ic.in_valid = 0; ic.in = '0;

        // Reset state (after first edge so everything is defined)
        #7;
        chk("rst_out",      64'(ia.out),       pol(64'h0, 4));
        chk("rst_valid",    64'(ia.out_valid), 64'd0);
        chk("rst_index",    64'(ia.index),     64'd0);
        chk("rst_wrap",     64'(ia.wrap),      64'd0);
        chk("rst_rdy_en0",  64'(ia.in_ready),  64'd0);
        ia.en = 1; ib.en = 1; ic.en = 1;
        #1;
        chk("rst_rdy_en1",  64'(ia.in_ready),  64'd1);
        tick();
        Reset_L = 1;
        tick(); tick();
        chk("idle_out",     64'(ia.out),       pol(64'h0, 4));
        chk("idle_valid",   64'(ia.out_valid), 64'd0);

        // Direct back-to-back on A, in=5 on C
        ia.mode = 0; ia.in_valid = 1; ia.in = 2'd0;
        ic.mode = 0; ic.in_valid = 1; ic.in = 3'd5;
        tick();
        chk("dir_a0",  64'(ia.out), pol(64'h1, 4));
        chk("dir_c5",  64'(ic.out), pol(64'h20, 8));
        chk("dir_c5i", 64'(ic.index), 64'd5);
        ic.in_valid = 0;
        ia.in = 2'd1; tick(); chk("dir_a1", 64'(ia.out), pol(64'h2, 4));
        ia.in = 2'd2; tick(); chk("dir_a2", 64'(ia.out), pol(64'h4, 4));
        ia.in = 2'd3; tick(); chk("dir_a3", 64'(ia.out), pol(64'h8, 4));
        chk("dir_a3i", 64'(ia.index), 64'd3);
        ia.in_valid = 0;
        tick();
        chk("dir_hold", 64'(ia.out), pol(64'h8, 4));

        // Scan on A, HOLD=1, start 2; a request during the scan is ignored
        ia.mode = 1; ia.in_valid = 1; ia.in = 2'd2;
        tick();
        chk("scan_4", 64'(ia.out), pol(64'h4, 4));
        chk("scan_rdy", 64'(ia.in_ready), 64'd0);
        ia.mode = 0; ia.in = 2'd0;
        tick(); chk("scan_8", 64'(ia.out), pol(64'h8, 4));
        tick(); chk("scan_1", 64'(ia.out), pol(64'h1, 4));
        chk("scan_wrap1", 64'(ia.wrap), 64'd1);
        tick(); chk("scan_2", 64'(ia.out), pol(64'h2, 4));
        chk("scan_wrap0", 64'(ia.wrap), 64'd0);
        tick();
        chk("scan_end_out", 64'(ia.out),       pol(64'h0, 4));
        chk("scan_end_vld", 64'(ia.out_valid), 64'd0);
        chk("scan_end_rdy", 64'(ia.in_ready),  64'd1);
        ia.in_valid = 0;
        tick();

        // Scan on B, HOLD=3, start 0, en low for 2 cycles on the second line
        ib.mode = 1; ib.in_valid = 1; ib.in = 2'd0;
        tick();
        ib.in_valid = 0;
        n = 1;
        for (int k = 0; k < 40; k++) begin
            if (k == 3) ib.en = 0;
            if (k == 5) ib.en = 1;
            tick();
            if (!ib.out_valid) break;
            n++;
        end
        ib.en = 1;
        chk("scan_b_len", 64'(n), 64'd14);

        // Asynchronous reset mid-scan on A
        ia.mode = 1; ia.in_valid = 1; ia.in = 2'd1;
        tick();
        ia.in_valid = 0;
        tick();
        #1 Reset_L = 0;
        #1;
        chk("arst_out",   64'(ia.out),       pol(64'h0, 4));
        chk("arst_valid", 64'(ia.out_valid), 64'd0);
        chk("arst_index", 64'(ia.index),     64'd0);
        chk("arst_wrap",  64'(ia.wrap),      64'd0);
        Reset_L = 1;
        ia.mode = 0; ia.in_valid = 1; ia.in = 2'd1;
        tick();
        chk("post_rst_dir", 64'(ia.out), pol(64'h2, 4));
        ia.in_valid = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1);
    end
endmodule
`default_nettype wire
